// File: rtl/ddr2_bank_ctrl_if.sv
// Request bus between the front-end and one DDR2 bank controller.
// The master presents a single request; the bank slave accepts it.
interface ddr2_bank_ctrl_if #(
  parameter int RA_W = 14,
  parameter int CA_W = 10,
  parameter int ID_W = 4
);
  logic            req_valid;
  logic            req_ready;
  logic [ID_W-1:0] req_id;
  logic [RA_W-1:0] req_ra;
  logic [CA_W-1:0] req_ca;
  logic            req_wr;

  modport master (
    output req_valid,
    output req_id,
    output req_ra,
    output req_ca,
    output req_wr,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_id,
    input  req_ra,
    input  req_ca,
    input  req_wr,
    output req_ready
  );
endinterface

// File: rtl/ddr2_bank_ctrl.sv
// Single-bank DDR2 open-page controller: holds one request and
// sequences ACT/RD/WR/PRE/REF requests to a shared scheduler.
module ddr2_bank_ctrl #(
  parameter int RA_W = 14,
  parameter int CA_W = 10,
  parameter int ID_W = 4,
  parameter int T_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [T_W-1:0]  t_rcd_m1,
  input  logic [T_W-1:0]  t_rp_m1,
  input  logic [T_W-1:0]  t_ras_m1,
  input  logic [T_W-1:0]  t_rtp_m1,
  input  logic [T_W-1:0]  t_wtp_m1,
  input  logic [T_W-1:0]  t_rfc_m1,
  ddr2_bank_ctrl_if.slave req,
  input  logic            ref_en,
  output logic            ref_done,
  output logic            act_req,
  output logic            rd_req,
  output logic            wr_req,
  output logic            pre_req,
  output logic            ref_req,
  input  logic            act_gnt,
  input  logic            rd_gnt,
  input  logic            wr_gnt,
  input  logic            pre_gnt,
  input  logic            ref_gnt,
  output logic [RA_W-1:0] sched_ra,
  output logic [CA_W-1:0] sched_ca,
  output logic [ID_W-1:0] sched_id
);

  typedef enum logic [2:0] {
    IDLE,
    ACTIVATING,
    ACTIVE,
    PRECHARGING,
    REFRESHING
  } state_t;

  state_t state, state_nxt;

  logic            held;
  logic [ID_W-1:0] h_id;
  logic [RA_W-1:0] h_ra;
  logic [CA_W-1:0] h_ca;
  logic            h_wr;
  logic [RA_W-1:0] open_row;

  logic [T_W-1:0] rcd_cnt;
  logic [T_W-1:0] ras_cnt;
  logic [T_W-1:0] c2p_cnt;
  logic [T_W-1:0] rp_cnt;
  logic [T_W-1:0] rfc_cnt;

  logic hit, pre_dem, accept;
  logic act_go, rd_go, wr_go;
  logic pre_go, ref_go;

  function automatic logic [T_W-1:0] dec(
    input logic [T_W-1:0] v
  );
    return (v == '0) ? v : v - 1'b1;
  endfunction

  assign hit     = held && (h_ra == open_row);
  assign pre_dem = (held && !hit) || (ref_en && !held);

  assign req.req_ready = rst_n && !held && !ref_en &&
                         (state != REFRESHING);
  assign accept = req.req_valid && req.req_ready;

  assign sched_ra = h_ra;
  assign sched_ca = h_ca;
  assign sched_id = h_id;

  assign act_go = act_req && act_gnt;
  assign rd_go  = rd_req && rd_gnt;
  assign wr_go  = wr_req && wr_gnt;
  assign pre_go = pre_req && pre_gnt;
  assign ref_go = ref_req && ref_gnt;

  // Wait states exit one cycle early so the follow-on request
  // appears exactly t_x_m1+1 cycles after the grant.
  always_comb begin
    state_nxt = state;
    act_req   = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    pre_req   = 1'b0;
    ref_req   = 1'b0;
    ref_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ref_en) begin
          ref_req = 1'b1;
          if (ref_gnt) state_nxt = REFRESHING;
        end else if (held) begin
          act_req = 1'b1;
          if (act_gnt) begin
            state_nxt = (t_rcd_m1 == '0) ?
                        ACTIVE : ACTIVATING;
          end
        end
      end
      ACTIVATING: begin
        if (rcd_cnt <= T_W'(1)) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (hit) begin
          rd_req = !h_wr;
          wr_req = h_wr;
        end else if (pre_dem && ras_cnt == '0 &&
                     c2p_cnt == '0) begin
          pre_req = 1'b1;
          if (pre_gnt) begin
            state_nxt = (t_rp_m1 == '0) ?
                        IDLE : PRECHARGING;
          end
        end
      end
      PRECHARGING: begin
        if (rp_cnt <= T_W'(1)) state_nxt = IDLE;
      end
      REFRESHING: begin
        if (rfc_cnt == '0) begin
          ref_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      act_req  = 1'b0;
      rd_req   = 1'b0;
      wr_req   = 1'b0;
      pre_req  = 1'b0;
      ref_req  = 1'b0;
      ref_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      held     <= 1'b0;
      h_id     <= '0;
      h_ra     <= '0;
      h_ca     <= '0;
      h_wr     <= 1'b0;
      open_row <= '0;
      rcd_cnt  <= '0;
      ras_cnt  <= '0;
      c2p_cnt  <= '0;
      rp_cnt   <= '0;
      rfc_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      rcd_cnt <= dec(rcd_cnt);
      ras_cnt <= dec(ras_cnt);
      c2p_cnt <= dec(c2p_cnt);
      rp_cnt  <= dec(rp_cnt);
      rfc_cnt <= dec(rfc_cnt);
      if (accept) begin
        held <= 1'b1;
        h_id <= req.req_id;
        h_ra <= req.req_ra;
        h_ca <= req.req_ca;
        h_wr <= req.req_wr;
      end else if (rd_go || wr_go) begin
        held <= 1'b0;
      end
      if (act_go) begin
        open_row <= h_ra;
        rcd_cnt  <= t_rcd_m1;
        ras_cnt  <= t_ras_m1;
      end
      if (rd_go) c2p_cnt <= t_rtp_m1;
      if (wr_go) c2p_cnt <= t_wtp_m1;
      if (pre_go) rp_cnt <= t_rp_m1;
      if (ref_go) rfc_cnt <= t_rfc_m1;
    end
  end

endmodule

// File: tb/tb_ddr2_bank_ctrl.sv
// Scoreboard bench for ddr2_bank_ctrl: directed scenarios, then
// randomized traffic checked against a timestamp-based bank model.
module tb_ddr2_bank_ctrl;
  localparam int RA_W = 14;
  localparam int CA_W = 10;
  localparam int ID_W = 4;
  localparam int T_W  = 8;
  localparam int A = 4, R = 3, W = 2, P = 1, F = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [T_W-1:0] t_rcd, t_rp, t_ras, t_rtp, t_wtp, t_rfc;
  logic ref_en, ref_done;
  logic act_req, rd_req, wr_req, pre_req, ref_req;
  logic act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [RA_W-1:0] sched_ra;
  logic [CA_W-1:0] sched_ca;
  logic [ID_W-1:0] sched_id;

  ddr2_bank_ctrl_if #(
    .RA_W(RA_W), .CA_W(CA_W), .ID_W(ID_W)
  ) bus ();

  ddr2_bank_ctrl #(
    .RA_W(RA_W), .CA_W(CA_W), .ID_W(ID_W), .T_W(T_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .t_rcd_m1(t_rcd), .t_rp_m1(t_rp),
    .t_ras_m1(t_ras), .t_rtp_m1(t_rtp),
    .t_wtp_m1(t_wtp), .t_rfc_m1(t_rfc),
    .req(bus),
    .ref_en(ref_en), .ref_done(ref_done),
    .act_req(act_req), .rd_req(rd_req),
    .wr_req(wr_req), .pre_req(pre_req),
    .ref_req(ref_req),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt),
    .wr_gnt(wr_gnt), .pre_gnt(pre_gnt),
    .ref_gnt(ref_gnt),
    .sched_ra(sched_ra), .sched_ca(sched_ca),
    .sched_id(sched_id)
  );

  typedef struct {
    logic [ID_W-1:0] id;
    logic [RA_W-1:0] ra;
    logic [CA_W-1:0] ca;
    logic            wr;
    int              acc;
  } ent_t;

  ent_t q[$];
  int cyc = 0;
  int n_pass = 0;
  int n_tot = 0;
  int gnt_pct = 100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input longint got,
                     input longint exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d exp=%0d",
                  nm, cyc, got, exp);
  endtask

  // Scheduler: grant a pending request with probability gnt_pct.
  initial begin
    {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} = '0;
    forever begin
      @(negedge clk); #1;
      act_gnt = act_req && ($urandom_range(99) < gnt_pct);
      rd_gnt  = rd_req && ($urandom_range(99) < gnt_pct);
      wr_gnt  = wr_req && ($urandom_range(99) < gnt_pct);
      pre_gnt = pre_req && ($urandom_range(99) < gnt_pct);
      ref_gnt = ref_req && ($urandom_range(99) < gnt_pct);
    end
  end

  // Reference model: bank state as timestamps of the last grants.
  bit m_open, m_inref, col_wr;
  logic [RA_W-1:0] m_row;
  int t_act, t_col, t_pre, t_ref;
  logic [4:0] prev;
  int rise[5] = '{default: -1};
  int gnt_at[5] = '{default: -1};
  int done_at = -1;
  int col_cnt = 0;

  task automatic model_reset();
    m_open = 0; m_inref = 0; col_wr = 0;
    t_act = -1000; t_col = -1000;
    t_pre = -1000; t_ref = -1000;
    q.delete();
  endtask

  task automatic mon_step();
    logic [4:0] dv, ev, gv;
    bit held, hit, exp_done, exp_rdy;
    int c, ctp;
    c = cyc;
    dv = {act_req, rd_req, wr_req, pre_req, ref_req};
    if (!rst_n) begin
      chk("rst_reqs", dv, 0);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_done", ref_done, 0);
      model_reset();
      prev = '0;
      return;
    end
    ev = '0;
    exp_done = 0;
    held = (q.size() > 0) && (q[0].acc < c);
    hit = held && m_open && (q[0].ra == m_row);
    ctp = col_wr ? int'(t_wtp) : int'(t_rtp);
    if (m_inref) begin
      exp_done = (c == t_ref + int'(t_rfc) + 1);
    end else if (!m_open) begin
      if (c > t_pre + int'(t_rp)) begin
        if (ref_en) ev[F] = 1'b1;
        else if (held) ev[A] = 1'b1;
      end
    end else if (c > t_act + int'(t_rcd)) begin
      if (hit) ev[q[0].wr ? W : R] = 1'b1;
      else if ((held || ref_en) &&
               c > t_act + int'(t_ras) &&
               c > t_col + ctp) ev[P] = 1'b1;
    end
    exp_rdy = !held && !ref_en && !m_inref;
    chk("req_vec", dv, ev);
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("ref_done", ref_done, exp_done);
    if (ev[A]) chk("act_ra", sched_ra, q[0].ra);
    if (ev[R] || ev[W]) begin
      chk("col_ra", sched_ra, q[0].ra);
      chk("col_ca", sched_ca, q[0].ca);
      chk("col_id", sched_id, q[0].id);
    end
    for (int k = 0; k < 5; k++)
      if (dv[k] && !prev[k]) rise[k] = c;
    prev = dv;
    gv = {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} & ev;
    for (int k = 0; k < 5; k++)
      if (gv[k]) gnt_at[k] = c;
    if (gv[A]) begin
      m_open = 1; m_row = q[0].ra; t_act = c;
    end
    if (gv[R] || gv[W]) begin
      t_col = c; col_wr = gv[W];
      void'(q.pop_front());
      col_cnt++;
    end
    if (gv[P]) begin
      m_open = 0; t_pre = c;
    end
    if (gv[F]) begin
      m_inref = 1; t_ref = c;
    end
    if (exp_done) begin
      m_inref = 0; done_at = c;
    end
  endtask

  initial begin
    model_reset();
    prev = '0;
    forever begin
      @(negedge clk); #2;
      mon_step();
    end
  end

  task automatic send(input logic [ID_W-1:0] id,
                      input logic [RA_W-1:0] ra,
                      input logic [CA_W-1:0] ca,
                      input logic wr,
                      output int acc);
    ent_t e;
    acc = -1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_id = id; bus.req_ra = ra;
    bus.req_ca = ca; bus.req_wr = wr;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (bus.req_ready) begin
        acc = cyc;
        e = '{id, ra, ca, wr, cyc};
        q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("send_timeout", 1, 0);
  endtask

  task automatic do_refresh(output int ready_hi);
    ready_hi = 0;
    @(negedge clk);
    ref_en = 1'b1;
    for (int k = 0; k < 400; k++) begin
      #1;
      if (bus.req_ready) ready_hi++;
      if (ref_done) begin
        @(negedge clk);
        ref_en = 1'b0;
        return;
      end
      @(negedge clk);
    end
    ref_en = 1'b0;
    chk("refresh_timeout", 1, 0);
  endtask

  task automatic wait_col(input int target);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #3;
      if (col_cnt >= target) return;
    end
    chk("col_timeout", col_cnt, target);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rh, a_open, w_gnt, t0, tgt;
    bus.req_valid = 1'b0;
    bus.req_id = '0; bus.req_ra = '0;
    bus.req_ca = '0; bus.req_wr = 1'b0;
    ref_en = 1'b0;
    t_rcd = 2; t_rp = 2; t_ras = 7;
    t_rtp = 1; t_wtp = 4; t_rfc = 10;
    do_reset(2);
    #1;
    chk("ready_after_rst", bus.req_ready, 1);

    // Row open then read
    send(4'd1, 14'd5, 10'd10, 1'b0, acc);
    wait_col(1);
    chk("act_latency", gnt_at[A] - acc, 1);
    chk("rcd_latency", rise[R] - gnt_at[A], 3);
    @(negedge clk); #1;
    chk("ready_after_col", bus.req_ready, 1);

    // Row hit write
    send(4'd2, 14'd5, 10'd20, 1'b1, acc);
    wait_col(2);
    chk("hit_latency", rise[W] - acc, 1);
    chk("hit_no_act_pre",
        (rise[A] < acc) && (rise[P] < acc), 1);
    a_open = gnt_at[A];
    w_gnt = gnt_at[W];

    // Row miss read to ra=9
    send(4'd3, 14'd9, 10'd30, 1'b0, acc);
    wait_col(3);
    chk("miss_pre_rise", rise[P],
        (a_open + 8 > w_gnt + 5) ? a_open + 8 : w_gnt + 5);
    chk("rp_to_act", rise[A] - gnt_at[P], 3);

    // Refresh with open row, nothing held
    t0 = cyc;
    do_refresh(rh);
    chk("ref_pre_first",
        (rise[P] > t0) && (rise[F] > gnt_at[P]), 1);
    chk("rfc_latency", done_at - gnt_at[F], 11);
    chk("ready_low_ref", rh, 0);

    // Reset while ACTIVATING
    send(4'd4, 14'd3, 10'd1, 1'b0, acc);
    #3;
    chk("act_before_rst", gnt_at[A], acc + 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_reqs",
        {act_req, rd_req, wr_req, pre_req, ref_req}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_release", bus.req_ready, 1);
    tgt = col_cnt + 1;
    send(4'd5, 14'd6, 10'd2, 1'b1, acc);
    wait_col(tgt);
    chk("reactivate", rise[A], acc + 1);

    // req_valid together with ref_en in IDLE
    do_reset(1);
    @(negedge clk);
    ref_en = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_ra = 14'd7;
    #1;
    chk("simul_ready", bus.req_ready, 0);
    chk("simul_ref_req", ref_req, 1);
    bus.req_valid = 1'b0;
    do_refresh(rh);

    // Randomized phases
    for (int ph = 0; ph < 6; ph++) begin
      gnt_pct = $urandom_range(100, 30);
      @(negedge clk);
      rst_n = 1'b0;
      t_rcd = T_W'($urandom_range(4));
      t_rp  = T_W'($urandom_range(4));
      t_ras = T_W'($urandom_range(9));
      t_rtp = T_W'($urandom_range(4));
      t_wtp = T_W'($urandom_range(6));
      t_rfc = T_W'($urandom_range(12));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (60) begin
        int r;
        r = $urandom_range(99);
        if (r < 70) begin
          send(ID_W'($urandom), RA_W'($urandom_range(3)),
               CA_W'($urandom), 1'($urandom), acc);
        end else if (r < 80) begin
          do_refresh(rh);
          chk("ready_low_ref_rnd", rh, 0);
        end else if (r < 95) begin
          repeat ($urandom_range(10, 1)) @(negedge clk);
        end else begin
          @(negedge clk);
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
        end
      end
      repeat (40) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
